// File: rtl/rst_cond_pkg.sv
// Shared types and defaults for the reset conditioner.
package rst_cond_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    SYNC  = 2'd1,
    HOLD  = 2'd2,
    RUN   = 2'd3
  } rc_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_MIN_PULSE   = 3;

  // Bits needed to count 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset chain. Flags the cycle just before its
// output flop loads 1, so the consumer can act on the same edge the chain releases.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic release_edge
);

  logic [STAGES-1:0] chain_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          chain_reg[gi] <= 1'b1;
        end else begin
          chain_reg[gi] <= chain_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign release_edge = chain_reg[STAGES-2] & ~chain_reg[STAGES-1];

endmodule

// File: rtl/rst_conditioner.sv
// Reset conditioner: synchronized release, minimum-width stretch, and a
// glitch-filtered soft reset, followed by a registered downstream valid.
module rst_conditioner
  import rst_cond_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int MIN_PULSE   = DEF_MIN_PULSE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  output logic       rst_out_n,
  output logic       valid,
  output logic [1:0] state_o
);

  localparam int HW = cnt_width(HOLD_CYCLES - 1);
  localparam int FW = cnt_width(MIN_PULSE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(MIN_PULSE - 1);

  rc_state_t       state_reg, state_next;
  logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [FW-1:0]   filt_cnt_reg, filt_cnt_next;
  logic            rst_out_n_reg, rst_out_n_next;
  logic            valid_reg, valid_next;
  logic            release_edge;
  logic            soft_accept;

  reset_sync #(
    .STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .release_edge(release_edge)
  );

  assign soft_accept = sw_rst_req && (filt_cnt_reg == FILT_LAST);

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;

    if (!sw_rst_req) begin
      filt_cnt_next = '0;
    end else if (filt_cnt_reg == FILT_LAST) begin
      filt_cnt_next = filt_cnt_reg;
    end else begin
      filt_cnt_next = filt_cnt_reg + FW'(1);
    end

    unique case (state_reg)
      RESET: state_next = SYNC;
      SYNC: begin
        if (release_edge) begin
          state_next    = HOLD;
          hold_cnt_next = '0;
        end
      end
      HOLD: begin
        // A request still asserted keeps restarting the hold window.
        if (sw_rst_req) begin
          hold_cnt_next = '0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next = RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
        end
      end
      RUN: begin
        if (soft_accept) begin
          state_next    = HOLD;
          hold_cnt_next = '0;
        end
      end
      default: state_next = RESET;
    endcase

    rst_out_n_next = (state_next == RUN);
    // Valid trails the reset release by one full cycle.
    valid_next     = (state_reg == RUN) && (state_next == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RESET;
      hold_cnt_reg  <= '0;
      filt_cnt_reg  <= '0;
      rst_out_n_reg <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      filt_cnt_reg  <= filt_cnt_next;
      rst_out_n_reg <= rst_out_n_next;
      valid_reg     <= valid_next;
    end
  end

  assign rst_out_n = rst_out_n_reg;
  assign valid     = valid_reg;
  assign state_o   = state_reg;

endmodule
